// File: rtl/mem_bank_pkg.sv
// Shared defaults and request/response record types for the two-channel
// memory bank controller.
package mem_bank_pkg;

   localparam int DEF_ADDR_W = 2;
   localparam int DEF_DATA_W = 64;
   localparam int DEF_CNT_W  = 16;

   localparam int NUM_CHAN = 2;

   // Records at the default geometry; parameterised instances carry the
   // same fields as discrete ports.
   typedef struct packed {
      logic                  write;
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] wdata;
   } mem_req_t;

   typedef struct packed {
      logic                  write;
      logic [DEF_DATA_W-1:0] rdata;
   } mem_rsp_t;

endpackage

// File: rtl/mem_rw_chan.sv
// One channel's response register and request/response handshake.
// Read data is captured from the bank port at the edge that ends the fire cycle.
module mem_rw_chan
   import mem_bank_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic              stall,
   input  logic              rsp_ready,
   input  logic [DATA_W-1:0] bank_rdata,
   output logic              slot_free,
   output logic              req_ready,
   output logic              fire,
   output logic              rsp_valid,
   output logic              rsp_write,
   output logic [DATA_W-1:0] rsp_rdata
);

   logic              rsp_valid_reg, rsp_valid_next;
   logic              rsp_write_reg, rsp_write_next;
   logic [DATA_W-1:0] rsp_rdata_reg, rsp_rdata_next;

   // Kept as separate assigns so the arbiter's stall path is not seen as
   // looping back through this channel's state logic.
   assign slot_free = !rsp_valid_reg || rsp_ready;
   assign req_ready = slot_free && !stall && !rst;
   assign fire      = req_valid && req_ready;

   always_comb begin
      rsp_valid_next = rsp_valid_reg;
      rsp_write_next = rsp_write_reg;
      rsp_rdata_next = rsp_rdata_reg;
      if (fire) begin
         rsp_valid_next = 1'b1;
         rsp_write_next = req_write;
         rsp_rdata_next = req_write ? '0 : bank_rdata;
      end else if (rsp_ready) begin
         rsp_valid_next = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid_reg <= 1'b0;
         rsp_write_reg <= 1'b0;
         rsp_rdata_reg <= '0;
      end else begin
         rsp_valid_reg <= rsp_valid_next;
         rsp_write_reg <= rsp_write_next;
         rsp_rdata_reg <= rsp_rdata_next;
      end
   end

   assign rsp_valid = rsp_valid_reg;
   assign rsp_write = rsp_write_reg;
   assign rsp_rdata = rsp_rdata_reg;

endmodule

// File: rtl/mem_bank_2rw_ctrl.sv
// Two-channel controller for an external two-port bank: drives one bank port
// per channel and arbitrates same-address write collisions round-robin.
module mem_bank_2rw_ctrl
   import mem_bank_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = DEF_CNT_W
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              c0_req_valid,
   output logic              c0_req_ready,
   input  logic              c0_req_write,
   input  logic [ADDR_W-1:0] c0_req_addr,
   input  logic [DATA_W-1:0] c0_req_wdata,
   output logic              c0_rsp_valid,
   input  logic              c0_rsp_ready,
   output logic              c0_rsp_write,
   output logic [DATA_W-1:0] c0_rsp_rdata,
   input  logic              c1_req_valid,
   output logic              c1_req_ready,
   input  logic              c1_req_write,
   input  logic [ADDR_W-1:0] c1_req_addr,
   input  logic [DATA_W-1:0] c1_req_wdata,
   output logic              c1_rsp_valid,
   input  logic              c1_rsp_ready,
   output logic              c1_rsp_write,
   output logic [DATA_W-1:0] c1_rsp_rdata,
   output logic              RW0_en,
   output logic              RW0_wmode,
   output logic [ADDR_W-1:0] RW0_addr,
   output logic [DATA_W-1:0] RW0_wdata,
   input  logic [DATA_W-1:0] RW0_rdata,
   output logic              RW1_en,
   output logic              RW1_wmode,
   output logic [ADDR_W-1:0] RW1_addr,
   output logic [DATA_W-1:0] RW1_wdata,
   input  logic [DATA_W-1:0] RW1_rdata,
   output logic [CNT_W-1:0]  conflict_cnt
);

   logic [NUM_CHAN-1:0] req_valid, req_write, rsp_ready, req_ready;
   logic [NUM_CHAN-1:0] slot_free, fire, stall, rsp_valid, rsp_write;
   logic [NUM_CHAN-1:0] rw_en, rw_wmode;
   logic [ADDR_W-1:0]   req_addr   [NUM_CHAN];
   logic [DATA_W-1:0]   req_wdata  [NUM_CHAN];
   logic [DATA_W-1:0]   bank_rdata [NUM_CHAN];
   logic [DATA_W-1:0]   rsp_rdata  [NUM_CHAN];
   logic [ADDR_W-1:0]   rw_addr    [NUM_CHAN];
   logic [DATA_W-1:0]   rw_wdata   [NUM_CHAN];

   logic             conflict;
   logic             prio_reg, prio_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;

   assign req_valid     = {c1_req_valid, c0_req_valid};
   assign req_write     = {c1_req_write, c0_req_write};
   assign rsp_ready     = {c1_rsp_ready, c0_rsp_ready};
   assign req_addr[0]   = c0_req_addr;
   assign req_addr[1]   = c1_req_addr;
   assign req_wdata[0]  = c0_req_wdata;
   assign req_wdata[1]  = c1_req_wdata;
   assign bank_rdata[0] = RW0_rdata;
   assign bank_rdata[1] = RW1_rdata;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CHAN; gi++) begin : g_chan
         mem_rw_chan #(
            .DATA_W(DATA_W)
         ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .req_valid (req_valid[gi]),
            .req_write (req_write[gi]),
            .stall     (stall[gi]),
            .rsp_ready (rsp_ready[gi]),
            .bank_rdata(bank_rdata[gi]),
            .slot_free (slot_free[gi]),
            .req_ready (req_ready[gi]),
            .fire      (fire[gi]),
            .rsp_valid (rsp_valid[gi]),
            .rsp_write (rsp_write[gi]),
            .rsp_rdata (rsp_rdata[gi])
         );

         // Bank port is idle (all zero) unless this channel fires.
         assign rw_en[gi]    = fire[gi];
         assign rw_wmode[gi] = fire[gi] && req_write[gi];
         assign rw_addr[gi]  = fire[gi] ? req_addr[gi]  : '0;
         assign rw_wdata[gi] = fire[gi] ? req_wdata[gi] : '0;
      end
   endgenerate

   // Only a write/write collision on one address needs arbitration; a read
   // racing a write sees the pre-write contents through the bank's async read.
   assign conflict = !rst && (&req_valid) && (&req_write) && (&slot_free)
                     && (req_addr[0] == req_addr[1]);
   assign stall[0] = conflict &&  prio_reg;
   assign stall[1] = conflict && !prio_reg;

   always_comb begin
      prio_next = prio_reg;
      cnt_next  = cnt_reg;
      if (conflict) begin
         prio_next = !prio_reg;
         if (cnt_reg != {CNT_W{1'b1}}) begin
            cnt_next = cnt_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prio_reg <= 1'b0;
         cnt_reg  <= '0;
      end else begin
         prio_reg <= prio_next;
         cnt_reg  <= cnt_next;
      end
   end

   assign c0_req_ready = req_ready[0];
   assign c1_req_ready = req_ready[1];
   assign c0_rsp_valid = rsp_valid[0];
   assign c1_rsp_valid = rsp_valid[1];
   assign c0_rsp_write = rsp_write[0];
   assign c1_rsp_write = rsp_write[1];
   assign c0_rsp_rdata = rsp_rdata[0];
   assign c1_rsp_rdata = rsp_rdata[1];

   assign RW0_en    = rw_en[0];
   assign RW0_wmode = rw_wmode[0];
   assign RW0_addr  = rw_addr[0];
   assign RW0_wdata = rw_wdata[0];
   assign RW1_en    = rw_en[1];
   assign RW1_wmode = rw_wmode[1];
   assign RW1_addr  = rw_addr[1];
   assign RW1_wdata = rw_wdata[1];

   assign conflict_cnt = cnt_reg;

endmodule

// File: tb/tb_mem_bank_2rw_ctrl.sv
// Bench for mem_bank_2rw_ctrl: attached two-port bank model, directed scenarios,
// then randomized traffic scored against a transaction-level reference.
module tb_mem_bank_2rw_ctrl;
   import mem_bank_pkg::*;

   localparam int AW = DEF_ADDR_W;
   localparam int DW = DEF_DATA_W;
   localparam int CW = 4;
   localparam int DEPTH = 1 << AW;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic c0_req_ready, c1_req_ready, c0_rsp_valid, c1_rsp_valid;
   logic c0_rsp_write, c1_rsp_write;
   logic [DW-1:0] c0_rsp_rdata, c1_rsp_rdata;
   logic RW0_en, RW0_wmode, RW1_en, RW1_wmode;
   logic [AW-1:0] RW0_addr, RW1_addr;
   logic [DW-1:0] RW0_wdata, RW1_wdata, RW0_rdata, RW1_rdata;
   logic [CW-1:0] conflict_cnt;

   // Stimulus records, one per channel.
   mem_req_t req_in [2];
   logic     v_in   [2];
   logic     rr_in  [2];

   mem_bank_2rw_ctrl #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .c0_req_valid(v_in[0]), .c0_req_ready(c0_req_ready), .c0_req_write(req_in[0].write),
      .c0_req_addr(req_in[0].addr), .c0_req_wdata(req_in[0].wdata),
      .c0_rsp_valid(c0_rsp_valid), .c0_rsp_ready(rr_in[0]),
      .c0_rsp_write(c0_rsp_write), .c0_rsp_rdata(c0_rsp_rdata),
      .c1_req_valid(v_in[1]), .c1_req_ready(c1_req_ready), .c1_req_write(req_in[1].write),
      .c1_req_addr(req_in[1].addr), .c1_req_wdata(req_in[1].wdata),
      .c1_rsp_valid(c1_rsp_valid), .c1_rsp_ready(rr_in[1]),
      .c1_rsp_write(c1_rsp_write), .c1_rsp_rdata(c1_rsp_rdata),
      .RW0_en(RW0_en), .RW0_wmode(RW0_wmode), .RW0_addr(RW0_addr),
      .RW0_wdata(RW0_wdata), .RW0_rdata(RW0_rdata),
      .RW1_en(RW1_en), .RW1_wmode(RW1_wmode), .RW1_addr(RW1_addr),
      .RW1_wdata(RW1_wdata), .RW1_rdata(RW1_rdata),
      .conflict_cnt(conflict_cnt)
   );

   // Attached bank: asynchronous read, synchronous write per port.
   logic [DW-1:0] bank [DEPTH];
   assign RW0_rdata = bank[RW0_addr];
   assign RW1_rdata = bank[RW1_addr];
   always @(posedge clk) begin
      if (RW0_en && RW0_wmode) bank[RW0_addr] <= RW0_wdata;
      if (RW1_en && RW1_wmode) bank[RW1_addr] <= RW1_wdata;
   end

   logic          o_ready [2], o_en [2], o_wm [2], o_rv [2], o_rw [2];
   logic [AW-1:0] o_addr  [2];
   logic [DW-1:0] o_wdata [2], o_rd [2];
   assign o_ready[0] = c0_req_ready;  assign o_ready[1] = c1_req_ready;
   assign o_en[0]    = RW0_en;        assign o_en[1]    = RW1_en;
   assign o_wm[0]    = RW0_wmode;     assign o_wm[1]    = RW1_wmode;
   assign o_addr[0]  = RW0_addr;      assign o_addr[1]  = RW1_addr;
   assign o_wdata[0] = RW0_wdata;     assign o_wdata[1] = RW1_wdata;
   assign o_rv[0]    = c0_rsp_valid;  assign o_rv[1]    = c1_rsp_valid;
   assign o_rw[0]    = c0_rsp_write;  assign o_rw[1]    = c1_rsp_write;
   assign o_rd[0]    = c0_rsp_rdata;  assign o_rd[1]    = c1_rsp_rdata;

   // Reference: memory contents, one outstanding response per channel,
   // arbitration priority and conflict tally.
   logic [DW-1:0] ref_mem [DEPTH];
   logic          exp_v [2];
   logic          exp_w [2];
   logic [DW-1:0] exp_d [2];
   logic          ref_prio;
   int            ref_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int ch, input logic v, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
      v_in[ch]         = v;
      req_in[ch].write = w;
      req_in[ch].addr  = a;
      req_in[ch].wdata = d;
   endtask

   task automatic idle();
      for (int ch = 0; ch < 2; ch++) begin
         set_req(ch, 1'b0, 1'b0, '0, '0);
         rr_in[ch] = 1'b1;
      end
   endtask

   // Called just after a falling edge with inputs already driven.
   task automatic step();
      logic free [2];
      logic fire [2];
      logic conflict;
      int   loser;
      #1;
      for (int ch = 0; ch < 2; ch++) free[ch] = !exp_v[ch] || rr_in[ch];
      conflict = v_in[0] && v_in[1] && req_in[0].write && req_in[1].write &&
                 (req_in[0].addr == req_in[1].addr) && free[0] && free[1];
      loser = ref_prio ? 0 : 1;
      for (int ch = 0; ch < 2; ch++) begin
         logic rdy;
         rdy = free[ch] && !(conflict && ch == loser);
         fire[ch] = v_in[ch] && rdy;
         check_val($sformatf("c%0d_req_ready", ch), 64'(o_ready[ch]), 64'(rdy));
         check_val($sformatf("RW%0d_en", ch), 64'(o_en[ch]), 64'(fire[ch]));
         check_val($sformatf("RW%0d_wmode", ch), 64'(o_wm[ch]), 64'(fire[ch] && req_in[ch].write));
         check_val($sformatf("RW%0d_addr", ch), 64'(o_addr[ch]), fire[ch] ? 64'(req_in[ch].addr) : 64'd0);
         check_val($sformatf("RW%0d_wdata", ch), 64'(o_wdata[ch]), fire[ch] ? 64'(req_in[ch].wdata) : 64'd0);
         check_val($sformatf("c%0d_rsp_valid", ch), 64'(o_rv[ch]), 64'(exp_v[ch]));
         if (exp_v[ch]) begin
            check_val($sformatf("c%0d_rsp_write", ch), 64'(o_rw[ch]), 64'(exp_w[ch]));
            check_val($sformatf("c%0d_rsp_rdata", ch), 64'(o_rd[ch]), 64'(exp_d[ch]));
         end
      end
      check_val("conflict_cnt", 64'(conflict_cnt), 64'(ref_cnt));
      for (int ch = 0; ch < 2; ch++) begin
         if (fire[ch]) begin
            exp_v[ch] = 1'b1;
            exp_w[ch] = req_in[ch].write;
            exp_d[ch] = req_in[ch].write ? '0 : ref_mem[req_in[ch].addr];
            $display("t=%0t c%0d %s addr=%0d data=%h", $time, ch,
                     req_in[ch].write ? "WR" : "RD", req_in[ch].addr,
                     req_in[ch].write ? req_in[ch].wdata : exp_d[ch]);
         end else if (rr_in[ch]) begin
            exp_v[ch] = 1'b0;
         end
      end
      for (int ch = 0; ch < 2; ch++)
         if (fire[ch] && req_in[ch].write) ref_mem[req_in[ch].addr] = req_in[ch].wdata;
      if (conflict) begin
         ref_prio = !ref_prio;
         if (ref_cnt < CNT_MAX) ref_cnt++;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_bank(input string tag);
      for (int i = 0; i < DEPTH; i++)
         check_val($sformatf("%s_mem%0d", tag, i), bank[i], ref_mem[i]);
   endtask

   // Reset with write attempts on both channels; nothing may reach the bank.
   task automatic apply_reset(input int cycles);
      rst = 1'b1;
      for (int ch = 0; ch < 2; ch++) begin
         set_req(ch, 1'b1, 1'b1, AW'(ch), 64'hDEAD_0000 + 64'(ch));
         rr_in[ch] = 1'b1;
      end
      #1;
      for (int ch = 0; ch < 2; ch++) begin
         check_val($sformatf("rst_c%0d_rsp_valid", ch), 64'(o_rv[ch]), 64'd0);
         check_val($sformatf("rst_c%0d_rsp_write", ch), 64'(o_rw[ch]), 64'd0);
         check_val($sformatf("rst_c%0d_rsp_rdata", ch), 64'(o_rd[ch]), 64'd0);
         check_val($sformatf("rst_c%0d_req_ready", ch), 64'(o_ready[ch]), 64'd0);
         check_val($sformatf("rst_RW%0d_en", ch), 64'(o_en[ch]), 64'd0);
         check_val($sformatf("rst_RW%0d_wmode", ch), 64'(o_wm[ch]), 64'd0);
         check_val($sformatf("rst_RW%0d_addr", ch), 64'(o_addr[ch]), 64'd0);
         check_val($sformatf("rst_RW%0d_wdata", ch), 64'(o_wdata[ch]), 64'd0);
      end
      check_val("rst_conflict_cnt", 64'(conflict_cnt), 64'd0);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
      check_bank("rst");
      rst = 1'b0;
      idle();
      for (int ch = 0; ch < 2; ch++) exp_v[ch] = 1'b0;
      ref_prio = 1'b0;
      ref_cnt  = 0;
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         bank[i]    = {$urandom, $urandom};
         ref_mem[i] = bank[i];
      end
      idle();
      apply_reset(2);

      // Write then read back on channel 0.
      set_req(0, 1'b1, 1'b1, 2'd1, 64'hAA); step();
      set_req(0, 1'b1, 1'b0, 2'd1, 64'h0);  step();
      check_val("wr_rd_rsp_valid", 64'(c0_rsp_valid), 64'd1);
      check_val("wr_rd_rsp_rdata", c0_rsp_rdata, 64'hAA);
      idle(); step();

      // Write collision, channel 0 has priority.
      set_req(0, 1'b1, 1'b1, 2'd2, 64'h11);
      set_req(1, 1'b1, 1'b1, 2'd2, 64'h22); step();
      set_req(0, 1'b0, 1'b0, 2'd0, 64'h0);  step();
      idle(); step();
      check_val("conf1_mem2", bank[2], 64'h22);
      check_val("conf1_cnt", 64'(conflict_cnt), 64'd1);

      // Second collision, channel 1 now wins.
      set_req(0, 1'b1, 1'b1, 2'd2, 64'h33);
      set_req(1, 1'b1, 1'b1, 2'd2, 64'h44); step();
      set_req(1, 1'b0, 1'b0, 2'd0, 64'h0);  step();
      idle(); step();
      check_val("conf2_mem2", bank[2], 64'h33);
      check_val("conf2_cnt", 64'(conflict_cnt), 64'd2);

      // Response back-pressure holds the read result.
      set_req(0, 1'b1, 1'b0, 2'd3, 64'h0); rr_in[0] = 1'b0; step();
      set_req(0, 1'b1, 1'b0, 2'd0, 64'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         check_val("bp_hold_rdata", c0_rsp_rdata, ref_mem[3]);
         check_val("bp_req_ready", 64'(c0_req_ready), 64'd0);
      end
      set_req(0, 1'b0, 1'b0, 2'd0, 64'h0); rr_in[0] = 1'b1; step();
      check_val("bp_drained", 64'(c0_rsp_valid), 64'd0);

      // Read racing a write to the same entry sees the old value.
      set_req(0, 1'b1, 1'b1, 2'd0, 64'h5); step();
      set_req(0, 1'b1, 1'b0, 2'd0, 64'h0);
      set_req(1, 1'b1, 1'b1, 2'd0, 64'h9); step();
      check_val("rw_race_old", c0_rsp_rdata, 64'h5);
      idle();
      set_req(0, 1'b1, 1'b0, 2'd0, 64'h0); step();
      check_val("rw_race_new", c0_rsp_rdata, 64'h9);
      idle(); step();

      // Randomized traffic, biased toward collisions so the counter saturates.
      for (int n = 0; n < 1500; n++) begin
         for (int ch = 0; ch < 2; ch++) begin
            set_req(ch, $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 65,
                    AW'($urandom_range(0, 1) == 0 ? 0 : $urandom_range(0, DEPTH - 1)),
                    {$urandom, $urandom});
            rr_in[ch] = $urandom_range(0, 99) < 75;
         end
         step();
      end
      check_val("rand_cnt_sat", 64'(conflict_cnt), 64'(CNT_MAX));
      idle(); step(); step();
      check_bank("rand");

      // Reset while a response is held.
      set_req(0, 1'b1, 1'b0, 2'd1, 64'h0); rr_in[0] = 1'b0; step();
      check_val("pre_rst_rsp_valid", 64'(c0_rsp_valid), 64'd1);
      apply_reset(2);
      for (int n = 0; n < 200; n++) begin
         for (int ch = 0; ch < 2; ch++) begin
            set_req(ch, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    AW'($urandom_range(0, DEPTH - 1)), {$urandom, $urandom});
            rr_in[ch] = $urandom_range(0, 3) != 0;
         end
         step();
      end
      idle(); step(); step();
      check_bank("final");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
